// File: rtl/fft_burst_ctrl_if.sv
// Signal bundle around the FFT frame sequencer: sample stream, core sink/source, bin stream, status.
// slave is the sequencer's view; master is the surrounding environment's view.
interface fft_burst_ctrl_if #(
    parameter int DW   = 16,
    parameter int EXPW = 6,
    parameter int IW   = 10
);
    logic            start;
    logic            inverse_cfg;
    logic            err_clear;

    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_real;
    logic [DW-1:0]   in_imag;

    logic            fft_sink_valid;
    logic            fft_sink_ready;
    logic            fft_sink_sop;
    logic            fft_sink_eop;
    logic [1:0]      fft_sink_error;
    logic [DW-1:0]   fft_sink_real;
    logic [DW-1:0]   fft_sink_imag;
    logic            fft_inverse;

    logic            fft_source_valid;
    logic            fft_source_ready;
    logic            fft_source_sop;
    logic            fft_source_eop;
    logic [1:0]      fft_source_error;
    logic [DW-1:0]   fft_source_real;
    logic [DW-1:0]   fft_source_imag;
    logic [EXPW-1:0] fft_source_exp;

    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_real;
    logic [DW-1:0]   out_imag;
    logic [IW-1:0]   out_index;
    logic [EXPW-1:0] out_exp;
    logic            out_last;

    logic            busy;
    logic            frame_done;
    logic [1:0]      err_code;

    modport slave (
        input  start, inverse_cfg, err_clear,
        input  in_valid, in_real, in_imag,
        output in_ready,
        output fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_error,
        output fft_sink_real, fft_sink_imag, fft_inverse,
        input  fft_sink_ready,
        input  fft_source_valid, fft_source_sop, fft_source_eop, fft_source_error,
        input  fft_source_real, fft_source_imag, fft_source_exp,
        output fft_source_ready,
        output out_valid, out_real, out_imag, out_index, out_exp, out_last,
        input  out_ready,
        output busy, frame_done, err_code
    );

    modport master (
        output start, inverse_cfg, err_clear,
        output in_valid, in_real, in_imag,
        input  in_ready,
        input  fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_error,
        input  fft_sink_real, fft_sink_imag, fft_inverse,
        output fft_sink_ready,
        output fft_source_valid, fft_source_sop, fft_source_eop, fft_source_error,
        output fft_source_real, fft_source_imag, fft_source_exp,
        input  fft_source_ready,
        input  out_valid, out_real, out_imag, out_index, out_exp, out_last,
        output out_ready,
        input  busy, frame_done, err_code
    );
endinterface

// File: rtl/fft_burst_ctrl.sv
// Frames FFT_LEN samples into a burst-mode FFT core and collects the matching output frame,
// indexing bins and flagging core errors, framing violations and output timeouts.
module fft_burst_ctrl #(
    parameter int FFT_LEN = 1024,
    parameter int DW      = 16,
    parameter int EXPW    = 6,
    parameter int TIMEOUT = 65535
) (
    input  logic            clk,
    input  logic            reset,
    fft_burst_ctrl_if.slave bus
);
    localparam int IW  = $clog2(FFT_LEN);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]  LAST_IDX = IW'(FFT_LEN - 1);
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_OUT, UNLOAD, ERROR} state_e;
    typedef enum logic [1:0] {ERR_NONE, ERR_CORE, ERR_FRAME, ERR_TIMEOUT} err_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  in_cnt_q, in_cnt_d;
    logic [IW-1:0]  out_cnt_q, out_cnt_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           inverse_q, inverse_d;
    err_e           err_q, err_d;
    logic           done_q, done_d;

    err_e err_det;
    logic sink_fire, src_fire, out_last;
    logic in_ready, sink_valid, sink_sop, sink_eop, source_ready, out_valid;

    assign sink_fire = (state_q == LOAD) && bus.in_valid && bus.fft_sink_ready;
    assign src_fire  = ((state_q == WAIT_OUT) || (state_q == UNLOAD))
                       && bus.fft_source_valid && bus.out_ready;
    assign out_last  = (state_q == UNLOAD) && (out_cnt_q == LAST_IDX);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        wd_d         = wd_q;
        inverse_d    = inverse_q;
        err_d        = err_q;
        done_d       = 1'b0;
        err_det      = ERR_NONE;
        in_ready     = 1'b0;
        sink_valid   = 1'b0;
        sink_sop     = 1'b0;
        sink_eop     = 1'b0;
        source_ready = 1'b0;
        out_valid    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.fft_source_valid) begin
                    err_det = ERR_FRAME;
                end else if (bus.start) begin
                    state_d   = LOAD;
                    in_cnt_d  = '0;
                    inverse_d = bus.inverse_cfg;
                end
            end
            LOAD: begin
                sink_valid = bus.in_valid;
                in_ready   = bus.fft_sink_ready;
                sink_sop   = (in_cnt_q == '0);
                sink_eop   = (in_cnt_q == LAST_IDX);
                if (sink_fire) begin
                    in_cnt_d = in_cnt_q + IW'(1);
                    if (sink_eop) state_d = WAIT_OUT;
                end
                if (bus.fft_source_valid) err_det = ERR_FRAME;
            end
            WAIT_OUT, UNLOAD: begin
                source_ready = bus.out_ready;
                out_valid    = bus.fft_source_valid;
                if (src_fire) begin
                    wd_d = '0;
                    if (bus.fft_source_error != 2'b00) begin
                        err_det = ERR_CORE;
                    end else if (state_q == WAIT_OUT) begin
                        // bin 0 must open the frame and must not close it
                        if (!bus.fft_source_sop || bus.fft_source_eop) begin
                            err_det = ERR_FRAME;
                        end else begin
                            state_d   = UNLOAD;
                            out_cnt_d = IW'(1);
                        end
                    end else if (bus.fft_source_sop || (bus.fft_source_eop != out_last)) begin
                        err_det = ERR_FRAME;
                    end else begin
                        out_cnt_d = out_cnt_q + IW'(1);
                        if (out_last) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end else if (wd_q == WD_LAST) begin
                    err_det = ERR_TIMEOUT;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            ERROR: begin
                if (bus.err_clear) begin
                    state_d = IDLE;
                    err_d   = ERR_NONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_det != ERR_NONE) begin
            state_d = ERROR;
            err_d   = err_det;
            done_d  = 1'b0;
        end
        if (state_d != state_q) wd_d = '0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            wd_q      <= '0;
            inverse_q <= 1'b0;
            err_q     <= ERR_NONE;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            wd_q      <= wd_d;
            inverse_q <= inverse_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign bus.in_ready         = in_ready;
    assign bus.fft_sink_valid   = sink_valid;
    assign bus.fft_sink_sop     = sink_sop;
    assign bus.fft_sink_eop     = sink_eop;
    assign bus.fft_sink_error   = 2'b00;
    assign bus.fft_sink_real    = DW'(bus.in_real);
    assign bus.fft_sink_imag    = DW'(bus.in_imag);
    assign bus.fft_inverse      = inverse_q;
    assign bus.fft_source_ready = source_ready;
    assign bus.out_valid        = out_valid;
    assign bus.out_real         = DW'(bus.fft_source_real);
    assign bus.out_imag         = DW'(bus.fft_source_imag);
    assign bus.out_exp          = EXPW'(bus.fft_source_exp);
    assign bus.out_index        = (state_q == UNLOAD) ? out_cnt_q : '0;
    assign bus.out_last         = out_last;
    assign bus.busy             = (state_q != IDLE);
    assign bus.frame_done       = done_q;
    assign bus.err_code         = err_q;
endmodule

// File: tb/tb_fft_burst_ctrl.sv
// Directed-sequence bench for fft_burst_ctrl with randomized data and handshakes,
// checked against a frame-level model of sample order, bin indexing and error codes.
module tb_fft_burst_ctrl;
    localparam int FFT_LEN = 1024;
    localparam int DW      = 16;
    localparam int EXPW    = 6;
    localparam int IW      = 10;
    localparam int TIMEOUT = 100;
    localparam int LAST    = FFT_LEN - 1;
    localparam int BUDGET  = 20000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    logic exp_inv     = 1'b0;

    fft_burst_ctrl_if #(.DW(DW), .EXPW(EXPW), .IW(IW)) bus ();

    fft_burst_ctrl #(
        .FFT_LEN (FFT_LEN),
        .DW      (DW),
        .EXPW    (EXPW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_time_limit: observed no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic quiet_inputs();
        bus.start            = 1'b0;
        bus.inverse_cfg      = 1'b0;
        bus.err_clear        = 1'b0;
        bus.in_valid         = 1'b0;
        bus.in_real          = '0;
        bus.in_imag          = '0;
        bus.fft_sink_ready   = 1'b0;
        bus.fft_source_valid = 1'b0;
        bus.fft_source_sop   = 1'b0;
        bus.fft_source_eop   = 1'b0;
        bus.fft_source_error = 2'b00;
        bus.fft_source_real  = '0;
        bus.fft_source_imag  = '0;
        bus.fft_source_exp   = '0;
        bus.out_ready        = 1'b0;
    endtask

    task automatic do_start(input logic inv);
        bus.start       = 1'b1;
        bus.inverse_cfg = inv;
        exp_inv         = inv;
        @(posedge clk); #1;
        bus.start       = 1'b0;
        bus.inverse_cfg = ~inv;
        check("busy_after_start", bus.busy, 1);
        check("fft_inverse_latched", bus.fft_inverse, inv);
    endtask

    // Drives samples until n beats are accepted; sample k of the frame must carry sop at 0, eop at LAST.
    task automatic load_frame(input int n, input int rate, input bit wiggle);
        int sent = 0;
        int cyc  = 0;
        logic v, r;
        logic [DW-1:0] re, im;
        while (sent < n && cyc < BUDGET) begin
            v  = ($urandom_range(0, 99) < rate);
            r  = ($urandom_range(0, 99) < rate);
            re = DW'($urandom);
            im = DW'($urandom);
            bus.in_valid       = v;
            bus.fft_sink_ready = r;
            bus.in_real        = re;
            bus.in_imag        = im;
            if (wiggle) begin
                bus.start       = 1'($urandom_range(0, 1));
                bus.inverse_cfg = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            check("sink_valid", bus.fft_sink_valid, v);
            check("in_ready", bus.in_ready, r);
            check("inverse_hold_load", bus.fft_inverse, exp_inv);
            if (v && r) begin
                check("sink_sop", bus.fft_sink_sop, (sent == 0));
                check("sink_eop", bus.fft_sink_eop, (sent == LAST));
                check("sink_real", bus.fft_sink_real, re);
                check("sink_imag", bus.fft_sink_imag, im);
            end
            @(posedge clk); #1;
            if (v && r) sent++;
            cyc++;
        end
        bus.in_valid       = 1'b0;
        bus.fft_sink_ready = 1'b0;
        bus.start          = 1'b0;
        if (sent < n) check("load_budget", sent, n);
    endtask

    // Plays the core's output frame. fault_kind 1 raises eop early at fault_bin, 2 flags a core error there.
    task automatic unload_frame(input int rate, input int fault_bin, input int fault_kind,
                                input bit wiggle, input logic [EXPW-1:0] expv);
        int k   = 0;
        int cyc = 0;
        bit hit = 1'b0;
        logic v, r, sop, eop;
        logic [1:0] er;
        logic [DW-1:0] re, im;
        while (k < FFT_LEN && cyc < BUDGET && !hit) begin
            v   = ($urandom_range(0, 99) < rate);
            r   = ($urandom_range(0, 99) < rate);
            re  = DW'($urandom);
            im  = DW'($urandom);
            sop = (k == 0);
            eop = (k == LAST);
            er  = 2'b00;
            if (k == fault_bin && fault_kind == 1) eop = 1'b1;
            if (k == fault_bin && fault_kind == 2) er = 2'b01;
            bus.fft_source_valid = v;
            bus.fft_source_sop   = sop;
            bus.fft_source_eop   = eop;
            bus.fft_source_error = er;
            bus.fft_source_real  = re;
            bus.fft_source_imag  = im;
            bus.fft_source_exp   = expv;
            bus.out_ready        = r;
            if (wiggle) begin
                bus.start       = 1'($urandom_range(0, 1));
                bus.inverse_cfg = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            check("out_valid", bus.out_valid, v);
            check("source_ready", bus.fft_source_ready, r);
            check("out_index", bus.out_index, k);
            check("out_last", bus.out_last, (k == LAST));
            check("inverse_hold_unload", bus.fft_inverse, exp_inv);
            if (v) begin
                check("out_real", bus.out_real, re);
                check("out_imag", bus.out_imag, im);
                check("out_exp", bus.out_exp, expv);
            end
            @(posedge clk); #1;
            if (v && r) begin
                if (k == fault_bin) hit = 1'b1;
                k++;
            end
            cyc++;
        end
        bus.fft_source_valid = 1'b0;
        bus.fft_source_sop   = 1'b0;
        bus.fft_source_eop   = 1'b0;
        bus.fft_source_error = 2'b00;
        bus.out_ready        = 1'b0;
        bus.start            = 1'b0;
        if (k < FFT_LEN && !hit) check("unload_budget", k, FFT_LEN);
    endtask

    task automatic expect_frame_done();
        check("frame_done_pulse", bus.frame_done, 1);
        check("busy_after_frame", bus.busy, 0);
        check("err_after_frame", bus.err_code, 0);
        @(posedge clk); #1;
        check("frame_done_clear", bus.frame_done, 0);
    endtask

    task automatic expect_error(input logic [1:0] code);
        check("err_code", bus.err_code, code);
        check("busy_in_error", bus.busy, 1);
        check("no_frame_done", bus.frame_done, 0);
        bus.in_valid         = 1'b1;
        bus.fft_sink_ready   = 1'b1;
        bus.fft_source_valid = 1'b1;
        bus.out_ready        = 1'b1;
        bus.start            = 1'b1;
        @(negedge clk);
        check("err_in_ready", bus.in_ready, 0);
        check("err_sink_valid", bus.fft_sink_valid, 0);
        check("err_source_ready", bus.fft_source_ready, 0);
        check("err_out_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        quiet_inputs();
        check("err_holds", bus.err_code, code);
        check("start_ignored_err", bus.busy, 1);
        bus.err_clear = 1'b1;
        @(posedge clk); #1;
        bus.err_clear = 1'b0;
        check("err_cleared", bus.err_code, 0);
        check("idle_after_clear", bus.busy, 0);
    endtask

    initial begin
        quiet_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err_code, 0);
        check("rst_done", bus.frame_done, 0);
        check("rst_inverse", bus.fft_inverse, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_sink_valid", bus.fft_sink_valid, 0);
        check("rst_source_ready", bus.fft_source_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_index", bus.out_index, 0);
        check("rst_out_last", bus.out_last, 0);
        check("sink_error_zero", bus.fft_sink_error, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Nominal frame, continuous handshakes, inverse transform
        do_start(1'b1);
        load_frame(FFT_LEN, 100, 1'b0);
        unload_frame(100, -1, 0, 1'b0, EXPW'(3));
        expect_frame_done();

        // Random backpressure on both sides; start and inverse_cfg toggle mid-frame
        do_start(1'b0);
        load_frame(FFT_LEN, 50, 1'b1);
        unload_frame(50, -1, 0, 1'b1, EXPW'($urandom));
        expect_frame_done();

        // Early eop at bin 511 is a framing error
        do_start(1'b0);
        load_frame(FFT_LEN, 100, 1'b0);
        unload_frame(100, 511, 1, 1'b0, EXPW'(5));
        expect_error(2'd2);

        // Core error flag on bin 10
        do_start(1'b1);
        load_frame(FFT_LEN, 100, 1'b0);
        unload_frame(100, 10, 2, 1'b0, EXPW'(1));
        expect_error(2'd1);

        // Core never answers: timeout exactly TIMEOUT cycles after WAIT_OUT entry
        do_start(1'b0);
        load_frame(FFT_LEN, 100, 1'b0);
        bus.out_ready = 1'b1;
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        check("timeout_not_yet", bus.err_code, 0);
        @(posedge clk); #1;
        expect_error(2'd3);

        // Reset in the middle of a load, then a clean frame
        do_start(1'b1);
        load_frame(500, 100, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.frame_done, 0);
        check("midrst_inverse", bus.fft_inverse, 0);
        check("midrst_out_index", bus.out_index, 0);
        check("midrst_err", bus.err_code, 0);
        do_start(1'b0);
        load_frame(FFT_LEN, 70, 1'b0);
        unload_frame(70, -1, 0, 1'b0, EXPW'(7));
        expect_frame_done();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fft_burst_ctrl.md
# fft_burst_ctrl

Frame sequencer for the 16-bit, 1024-point burst-mode FFT core. It accepts a free-running complex sample stream and, per start request, frames exactly FFT_LEN samples into the core's sink with sop/eop and a latched inverse flag. It then collects the matching output frame with bin index and block exponent, and flags protocol errors and timeouts. It sits between the sample capture path and the magnitude/phase (atan2) stage.

## Interface

- FFT_LEN, 1024, points per frame (power of 2)
- DW, 16, sample/bin width per component
- EXPW, 6, block exponent width
- TIMEOUT, 65535, max cycles in WAIT_OUT without an accepted output beat
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse: begin one frame (honoured only in IDLE)
- inverse_cfg  in  1  sampled on accepted start
- err_clear  in  1  leaves ERROR, clears err_code
- in_valid / in_ready  in / out  1  sample stream handshake
- in_real, in_imag  in  DW  sample components
- fft_sink_valid, fft_sink_sop, fft_sink_eop  out  1  to core sink
- fft_sink_ready  in  1  from core
- fft_sink_error  out  2  constant 0
- fft_sink_real, fft_sink_imag  out  DW  to core
- fft_inverse  out  1  latched inverse_cfg
- fft_source_valid, fft_source_sop, fft_source_eop  in  1  from core
- fft_source_error  in  2  from core
- fft_source_real, fft_source_imag  in  DW  from core
- fft_source_exp  in  EXPW  from core
- fft_source_ready  out  1  to core
- out_valid / out_ready  out / in  1  bin stream handshake
- out_real, out_imag  out  DW  bin components
- out_index  out  log2(FFT_LEN)  bin number, 0..FFT_LEN-1
- out_exp  out  EXPW  block exponent for current bin
- out_last  out  1  high on bin FFT_LEN-1
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse per completed frame
- err_code  out  2  0 none, 1 core error, 2 framing, 3 timeout

## Operation

- States: IDLE, LOAD, WAIT_OUT, UNLOAD, ERROR.
- IDLE: in_ready=0, fft_source_ready=0. start=1 → LOAD; in_cnt=0; fft_inverse<=inverse_cfg.
- LOAD: combinational pass-through. fft_sink_valid=in_valid, in_ready=fft_sink_ready, data forwarded. fft_sink_sop=(in_cnt==0), fft_sink_eop=(in_cnt==FFT_LEN-1). in_cnt increments per beat where in_valid&fft_sink_ready. Accepted eop beat → WAIT_OUT.
- WAIT_OUT: fft_source_ready=out_ready, out_valid=fft_source_valid. First beat must carry fft_source_sop=1, else err 2. Accepted sop beat is bin 0 → UNLOAD, out_cnt=1.
- UNLOAD: pass-through. out_index=out_cnt. out_last=(out_cnt==FFT_LEN-1); fft_source_eop must equal out_last on every accepted beat, and sop must be 0, else err 2. Accepted last beat → IDLE, frame_done=1 next cycle.
- Any accepted output beat with fft_source_error!=0 → err 1 (priority over 2).
- fft_source_valid=1 while in IDLE or LOAD → err 2; fft_source_ready stays 0.
- Timeout: wd counter resets on state entry and on each accepted output beat, increments otherwise in WAIT_OUT/UNLOAD. Reaching TIMEOUT → err 3.
- ERROR: all readies/valids 0; err_code holds; err_clear → IDLE, err_code=0. start ignored.
- start outside IDLE ignored; inverse_cfg changes mid-frame have no effect.

## Timing

- Reset: state IDLE; counters 0; fft_inverse=0, err_code=0, frame_done=0; all valids/readies 0, so out_index=0, out_last=0.
- Sink and source paths: zero latency, combinational. Registered: state, counters, fft_inverse, err_code, frame_done.
- start in IDLE: LOAD on next edge; first sample can transfer that next cycle.
- Error detected on cycle n: ERROR and err_code set at edge n+1. The offending beat is still forwarded.
- Reset mid-frame: immediate return to IDLE with no frame_done. The external core must share the reset.
- Counters wrap to 0 at FFT_LEN; a wrap happens only on eop/last.

## Test plan

- Nominal: start, inverse_cfg=1, 1024 samples with continuous ready, core returns 1024 bins exp=3 → sop at sample 0 and eop at 1023, fft_inverse=1; out_index 0..1023, out_last at 1023, out_exp=3, frame_done one cycle, busy low after.
- Backpressure: random fft_sink_ready and out_ready (50%) → no beats lost or duplicated; index order preserved.
- Framing: core asserts source_eop at bin 511 → err_code=2 next cycle, state ERROR; err_clear → IDLE, err_code=0.
- Core error: source_error=2'b01 on bin 10 → err_code=1.
- Timeout: TIMEOUT=100, no source_valid after load → err_code=3 exactly 100 cycles after WAIT_OUT entry.
- Reset/start: reset at sample 500 → IDLE, counters 0. start during UNLOAD ignored; a new frame starts cleanly after.
